seq_adder_nibble: RTL and testbench
===================================

SEQ_ADDER_NIBBLE -- requirements
Module: seq_adder_nibble

Interface
REQ-001 SHALL have parameter N_NIBBLES, default 4, the number of 4-bit slices per operand; operand width W = 4*N_NIBBLES.
REQ-002 SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin an addition; sampled only in IDLE.
REQ-006 SHALL have ports a and b, input, W each, operands latched on an accepted start.
REQ-007 SHALL have port c_in, input, 1, initial carry, latched on an accepted start.
REQ-008 SHALL have port busy, output, 1, high in RUN.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port sum, output, W, result register.
REQ-011 SHALL have port c_out, output, 1, final carry-out.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-013 SHALL in IDLE with start=1 latch a, b, c_in, clear sum to 0, set nibble index to 0, and enter RUN.
REQ-014 SHALL in RUN compute one 4-bit slice per cycle, LSB first, using registered carry; slice i is written to sum[4i+3:4i]; the carry register updates.
REQ-015 SHALL enter DONE on the edge that writes slice N_NIBBLES-1; c_out takes the final carry on that same edge.
REQ-016 SHALL give fixed latency: start sampled at edge k gives done=1 during the cycle after edge k+N_NIBBLES.
REQ-017 SHALL hold done high exactly one cycle, then return to IDLE.
REQ-018 SHALL keep sum and c_out stable from DONE until the next accepted start.
REQ-019 SHALL ignore start in RUN and DONE, and SHALL NOT let changes on a/b/c_in during RUN affect the result.
REQ-020 SHALL accept start in the cycle immediately after done (back-to-back operation).
REQ-021 SHALL compute sum modulo 2^W, with c_out as bit W of a + b + c_in.

Reset
REQ-022 SHALL on rst=1 at any edge, including mid-RUN, force state IDLE, busy=0, done=0, sum=0, c_out=0, carry=0, index=0.
REQ-023 SHALL give rst priority over start in the same cycle.

Configuration
REQ-024 SHALL use macro SEQ_ADDER_SUBTRACT_EN.
- Defined: adds input port sub (1 bit), latched with the operands; sub=1 computes a + ~b + 1 (c_in ignored); c_out=1 means no borrow.
- Undefined: no sub port; addition only.

Structure
REQ-025 SHALL place the FSM state encoding (IDLE, RUN, DONE) and the slice-width constant (4) in a shared package, adder_pkg.
REQ-026 SHALL instantiate exactly one 4-bit ripple-carry adder sub-module (RCA_4_bit) as the per-cycle slice datapath; no other arithmetic.

Verification
REQ-027 SHALL test a=0x1234, b=0x4321, c_in=0 -> sum=0x5555, c_out=0, done exactly 4 cycles after start edge.
REQ-028 SHALL test a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1; a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1.
REQ-029 SHALL test start pulse during RUN with new operands -> ignored; first result unchanged; busy stays high for 4 cycles.
REQ-030 SHALL test rst asserted at second RUN cycle -> next cycle IDLE, busy=0, sum=0, c_out=0; no done pulse.
REQ-031 SHALL test back-to-back: second start the cycle after done with a=0x00FF, b=0x0001 -> sum=0x0100, c_out=0.
REQ-032 SHALL test, with SEQ_ADDER_SUBTRACT_EN defined: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0; a=0x0007, b=0x0005 -> sum=0x0002, c_out=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
// The optional subtract mode is selected with SEQ_ADDER_SUBTRACT_EN.
package adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of the slice index; a single-nibble build still needs one bit.
    function automatic int idx_width(input int n_slices);
        return (n_slices > 1) ? $clog2(n_slices) : 1;
    endfunction

endpackage

// File: rtl/seq_adder_nibble_rca.sv
// RCA_4_bit: one SLICE_W-bit ripple-carry adder, the only arithmetic in the
// nibble-serial adder datapath.
module RCA_4_bit
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_c,
    output logic [SLICE_W-1:0] o_s,
    output logic               o_c
);

    logic [SLICE_W:0] w_carry;

    assign w_carry[0] = i_c;

    for (genvar g = 0; g < SLICE_W; g++) begin : g_fa
        logic w_p;
        assign w_p            = i_a[g] ^ i_b[g];
        assign o_s[g]         = w_p ^ w_carry[g];
        assign w_carry[g + 1] = (i_a[g] & i_b[g]) | (w_carry[g] & w_p);
    end

    assign o_c = w_carry[SLICE_W];

endmodule

// File: rtl/seq_adder_nibble.sv
// Nibble-serial adder: one 4-bit slice per cycle, LSB first, fixed latency.
// Define SEQ_ADDER_SUBTRACT_EN to add the 'sub' port (a + ~b + 1).
module seq_adder_nibble
    import adder_pkg::*;
#(
    parameter  int N_NIBBLES = 4,
    localparam int W         = SLICE_W * N_NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
`ifdef SEQ_ADDER_SUBTRACT_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out,
    output state_t       o_dbg_state
);

    localparam int IDX_W = idx_width(N_NIBBLES);

    // Handshake: start is taken only in IDLE; done is a one-cycle pulse and
    // sum/c_out hold their value until the next accepted start.
    state_t             r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_busy;
    logic               r_done;
    logic               r_c_out;

    logic [W-1:0]       w_b_in;
    logic               w_c_in;
    logic [SLICE_W-1:0] w_a_slice;
    logic [SLICE_W-1:0] w_b_slice;
    logic [SLICE_W-1:0] w_s_slice;
    logic               w_c_slice;
    logic               w_last;

    // Subtraction is folded into the operand latch so the datapath only adds.
`ifdef SEQ_ADDER_SUBTRACT_EN
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : c_in;
`else
    assign w_b_in = b;
    assign w_c_in = c_in;
`endif

    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < N_NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_slice = r_a[SLICE_W*i +: SLICE_W];
                w_b_slice = r_b[SLICE_W*i +: SLICE_W];
            end
        end
    end

    assign w_last = (r_idx == IDX_W'(N_NIBBLES - 1));

    RCA_4_bit u_rca (
        .i_a (w_a_slice),
        .i_b (w_b_slice),
        .i_c (r_carry),
        .o_s (w_s_slice),
        .o_c (w_c_slice)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_c_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_c_in;
                        r_sum   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < N_NIBBLES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_sum[SLICE_W*i +: SLICE_W] <= w_s_slice;
                        end
                    end
                    r_carry <= w_c_slice;
                    if (w_last) begin
                        r_c_out <= w_c_slice;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign sum         = r_sum;
    assign c_out       = r_c_out;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_adder_nibble.sv
// Self-checking bench for seq_adder_nibble (default N_NIBBLES = 4).
// Subtract cases are exercised when SEQ_ADDER_SUBTRACT_EN is defined.
module tb_seq_adder_nibble;
    import adder_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    state_t       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_adder_nibble #(.N_NIBBLES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .c_in        (c_in),
`ifdef SEQ_ADDER_SUBTRACT_EN
        .sub         (sub),
`endif
        .busy        (busy),
        .done        (done),
        .sum         (sum),
        .c_out       (c_out),
        .o_dbg_state (dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: whole-word arithmetic, bit W is the carry-out.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else   r = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        return r;
    endfunction

    // Issues one operation, waits (bounded) for done, checks result and the
    // cycle after. Leaves the bench in the IDLE cycle that follows done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                          input logic tsub, input bit disturb, input string tag);
        logic [W:0] exp;
        int cyc;
        int busy_cyc;
        exp   = model(ta, tb_v, tci, tsub);
        a     = ta;
        b     = tb_v;
        c_in  = tci;
        sub   = tsub;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        check({tag, " sum_cleared"}, 32'(sum), 32'd0);
        busy_cyc = busy ? 1 : 0;
        cyc = 0;
        while (!done && cyc < 20) begin
            if (disturb) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
                c_in  = 1'($urandom_range(0, 1));
                sub   = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
            if (busy) busy_cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(N));
        check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(N));
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " sum"}, 32'(sum), 32'(exp[W-1:0]));
        check({tag, " c_out"}, 32'(c_out), 32'(exp[W]));
        tick();
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " sum_hold"}, 32'(sum), 32'(exp[W-1:0]));
        check({tag, " c_out_hold"}, 32'(c_out), 32'(exp[W]));
        check({tag, " idle"}, 32'(dbg_state), 32'(S_IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rci;
        logic         rsub;
        int           seen_done;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        sub   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset c_out", 32'(c_out), 32'd0);
        check("reset state", 32'(dbg_state), 32'(S_IDLE));

        // Directed cases issued back-to-back, the last one being the
        // 0x00FF + 0x0001 start in the cycle right after done.
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, "add_1234_4321");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "add_ffff_0001");
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, "add_ffff_cin");
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, "b2b_00ff_0001");

        // start pulses and operand churn during RUN must not matter.
        tick();
        run_op(16'hA5A5, 16'h0F0F, 1'b1, 1'b0, 1'b1, "ignore_start_run");

        // Reset in the second RUN cycle aborts the operation.
        a     = 16'h8888;
        b     = 16'h8888;
        c_in  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_rst busy", 32'(busy), 32'd0);
        check("midrun_rst sum", 32'(sum), 32'd0);
        check("midrun_rst c_out", 32'(c_out), 32'd0);
        check("midrun_rst state", 32'(dbg_state), 32'(S_IDLE));
        seen_done = 0;
        repeat (8) begin
            tick();
            if (done) seen_done++;
        end
        check("midrun_rst no_done", 32'(seen_done), 32'd0);

        // rst wins over start in the same cycle.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_prio busy", 32'(busy), 32'd0);
        check("rst_prio state", 32'(dbg_state), 32'(S_IDLE));
        tick();
        check("rst_prio still_idle", 32'(dbg_state), 32'(S_IDLE));

`ifdef SEQ_ADDER_SUBTRACT_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, "sub_5_7");
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0, "sub_7_5");
`endif

        for (int i = 0; i < 20; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rci  = 1'($urandom_range(0, 1));
`ifdef SEQ_ADDER_SUBTRACT_EN
            rsub = 1'($urandom_range(0, 1));
`else
            rsub = 1'b0;
`endif
            if (i % 4 == 3) begin
                ra = '1;
                rb = W'(i);
            end
            run_op(ra, rb, rci, rsub, bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
